maestro_memoria: RTL and testbench
==================================

Name: maestro_memoria

Overview:
- Bus initiator that drives the 16x16 instruction/data memory on behalf of the CPU core: single-word writes and pipelined burst reads.
- Converts a CPU-side request/busy handshake into the memory's HabilitarSalida/HabilitarEscritura/Direccion/Entrada strobes.
- Captures registered Salida data one cycle after each read strobe.
- Sits between the control unit and the memory instance in the ciscud top level.

Parameters:
ANCHO_DATOS, 16, width of data words and address bus
PROFUNDIDAD, 16, number of memory words; valid addresses 0..PROFUNDIDAD-1
DIR_PROTEGIDAS, 2, addresses 0..DIR_PROTEGIDAS-1 hold the boot load-immediate and are write-protected

Ports:
Reloj  input  1  clock, all logic on rising edge
Reiniciar  input  1  synchronous active-low reset
Solicitud  input  1  CPU request; sampled only when Ocupado=0
Escribir  input  1  1=write, 0=read; sampled with Solicitud
DireccionCPU  input  16  base address
DatoCPU  input  16  write data
Cantidad  input  5  read burst length 1..16; ignored for writes
Ocupado  output  1  transaction in progress
DatoLeido  output  16  captured read word
DatoValido  output  1  one-cycle pulse per captured word
Fin  output  1  one-cycle pulse on transaction completion
Error  output  1  one-cycle pulse on a rejected request
HabilitarSalida  output  1  memory read strobe
HabilitarEscritura  output  1  memory write strobe
Direccion  output  16  memory address
Entrada  output  16  memory write data
Salida  input  16  memory read data, valid the cycle after its strobe edge

Behaviour:
- Reset (Reiniciar=0 at an edge): state REPOSO. All outputs 0 (DatoLeido=0x0000, Direccion=0x0000, Entrada=0x0000). Reset wins over any in-flight burst; no further strobes are issued.
- All outputs are registered. HabilitarSalida and HabilitarEscritura are never 1 in the same cycle.
- States: REPOSO, LEER, VACIAR, ESCRIBIR, FIN.
- REPOSO with Solicitud=1 at edge E0: request is validated and latched, then:
  - Invalid: Error=1 for one cycle, no strobe, remain REPOSO, Ocupado stays 0.
  - Invalid read: Cantidad=0, or DireccionCPU+Cantidad-1 > PROFUNDIDAD-1 (17-bit compare).
  - Invalid write: DireccionCPU >= PROFUNDIDAD, or DireccionCPU < DIR_PROTEGIDAS.
- Read (valid):
  - After E0: state LEER, Ocupado=1, HabilitarSalida=1, Direccion=base.
  - Each following edge while words remain to issue: Direccion increments by 1.
  - After N strobes: HabilitarSalida=0, state VACIAR.
  - Word k is strobed at edge E(k+1) and sampled from Salida at edge E(k+2). DatoLeido is updated and DatoValido=1 after E2..E(N+1).
  - Fin=1 together with the last DatoValido; Ocupado falls at the same edge.
  - Total: N+1 cycles from acceptance to Fin.
- Write (valid):
  - After E0: state ESCRIBIR, HabilitarEscritura=1, Direccion=base, Entrada=DatoCPU, Ocupado=1.
  - Memory writes at E1. After E1: strobe 0, Fin=1, Ocupado=0.
- Solicitud while Ocupado=1 is ignored (not queued).
- A new request is accepted on the edge where Fin is driven high (back-to-back allowed); Fin/DatoValido from the prior transaction still pulse.
- Entrada returns to 0x0000 when HabilitarEscritura=0.
- Salida is sampled only in capture cycles, so the bus value (including z) in other cycles is don't-care.

Test Plan:
- Reset mid-burst: Reiniciar=0 during a 4-word read after 2 strobes -> next cycle all strobes 0, Ocupado=0, DatoValido=0, and no further DatoValido pulses.
- Boot read: memory post-boot, read base 0x0000 Cantidad=2 -> DatoValido after E2 with 0x4000 and after E3 with 0x0017; Fin with the second word; Ocupado high for exactly 3 cycles.
- Write then read: write 0x00A5 to 0x0007, then read 0x0007 Cantidad=1 -> write strobe for one cycle with Direccion=0x0007, Fin after E1; the read returns DatoLeido=0x00A5.
- Full burst: read base 0 Cantidad=16 -> 16 consecutive DatoValido pulses, Direccion 0x0000..0x000F, never 0x0010; Fin on the 16th.
- Rejections, each giving one Error pulse with no strobe: write to 0x0001; read base 0x000E Cantidad=3; Cantidad=0; write to 0x0010.
- Busy handling: Solicitud held high during a 4-word read -> ignored; a new read is accepted on the Fin edge and its first strobe appears the next cycle.

Source files
------------

// File: rtl/maestro_memoria_if.sv
// maestro_memoria_if: CPU-side request/busy handshake plus memory strobe bus.
//   master modport: the memory initiator (accepts CPU requests, drives memory strobes)
//   slave modport : the CPU core and memory instance facing the initiator
//   CPU side   : Solicitud, Escribir, DireccionCPU, DatoCPU, Cantidad -> Ocupado, DatoLeido, DatoValido, Fin, Error
//   memory side: HabilitarSalida, HabilitarEscritura, Direccion, Entrada -> Salida
interface maestro_memoria_if #(parameter int ANCHO_DATOS = 16);
    logic                   Solicitud;
    logic                   Escribir;
    logic [ANCHO_DATOS-1:0] DireccionCPU;
    logic [ANCHO_DATOS-1:0] DatoCPU;
    logic [4:0]             Cantidad;
    logic                   Ocupado;
    logic [ANCHO_DATOS-1:0] DatoLeido;
    logic                   DatoValido;
    logic                   Fin;
    logic                   Error;
    logic                   HabilitarSalida;
    logic                   HabilitarEscritura;
    logic [ANCHO_DATOS-1:0] Direccion;
    logic [ANCHO_DATOS-1:0] Entrada;
    logic [ANCHO_DATOS-1:0] Salida;

    modport master (
        input  Solicitud, Escribir, DireccionCPU, DatoCPU, Cantidad, Salida,
        output Ocupado, DatoLeido, DatoValido, Fin, Error,
               HabilitarSalida, HabilitarEscritura, Direccion, Entrada
    );

    modport slave (
        output Solicitud, Escribir, DireccionCPU, DatoCPU, Cantidad, Salida,
        input  Ocupado, DatoLeido, DatoValido, Fin, Error,
               HabilitarSalida, HabilitarEscritura, Direccion, Entrada
    );
endinterface

// File: rtl/maestro_memoria.sv
// maestro_memoria: memory bus initiator doing single-word writes and pipelined burst reads.
//   Reloj     : clock, rising edge
//   Reiniciar : synchronous active-low reset
//   bus       : maestro_memoria_if.master (CPU handshake in/out, memory strobes out, Salida in)
module maestro_memoria #(
    parameter int ANCHO_DATOS    = 16,
    parameter int PROFUNDIDAD    = 16,
    parameter int DIR_PROTEGIDAS = 2
) (
    input  logic Reloj,
    input  logic Reiniciar,
    maestro_memoria_if.master bus
);
    typedef enum logic [2:0] {REPOSO, LEER, VACIAR, ESCRIBIR, FIN} estado_t;

    estado_t                estado, estado_sig;
    logic [4:0]             faltan, faltan_sig;
    logic                   hs_d;
    logic [ANCHO_DATOS-1:0] dir_sig, ent_sig, dato_sig;
    logic                   ocupado_sig, valido_sig, fin_sig, error_sig, hs_sig, he_sig;
    logic [ANCHO_DATOS:0]   ultima;
    logic                   lectura_ok, escritura_ok;

    // Last burst address in one extra bit so a burst running past the top cannot wrap.
    assign ultima       = {1'b0, bus.DireccionCPU} + (ANCHO_DATOS+1)'(bus.Cantidad) - 1'b1;
    assign lectura_ok   = bus.Cantidad != 5'd0 && ultima <= (ANCHO_DATOS+1)'(PROFUNDIDAD - 1);
    assign escritura_ok = bus.DireccionCPU < ANCHO_DATOS'(PROFUNDIDAD)
                       && bus.DireccionCPU >= ANCHO_DATOS'(DIR_PROTEGIDAS);

    always_comb begin
        estado_sig  = estado;
        faltan_sig  = faltan;
        dir_sig     = bus.Direccion;
        ent_sig     = '0;
        // hs_d marks that the memory registered a read word on the previous edge.
        dato_sig    = hs_d ? bus.Salida : bus.DatoLeido;
        valido_sig  = hs_d;
        // VACIAR and ESCRIBIR each last one cycle and end on their completion edge.
        fin_sig     = estado == VACIAR || estado == ESCRIBIR;
        ocupado_sig = 1'b0;
        error_sig   = 1'b0;
        hs_sig      = 1'b0;
        he_sig      = 1'b0;
        if (estado == LEER) begin
            ocupado_sig = 1'b1;
            if (faltan != 5'd0) begin
                hs_sig     = 1'b1;
                dir_sig    = bus.Direccion + 1'b1;
                faltan_sig = faltan - 5'd1;
            end else begin
                estado_sig = VACIAR;
            end
        end else begin
            // Idle and completion edges both accept a request, giving back-to-back transfers.
            estado_sig = fin_sig ? FIN : REPOSO;
            if (bus.Solicitud) begin
                if (bus.Escribir ? !escritura_ok : !lectura_ok) begin
                    error_sig = 1'b1;
                end else if (bus.Escribir) begin
                    estado_sig  = ESCRIBIR;
                    he_sig      = 1'b1;
                    dir_sig     = bus.DireccionCPU;
                    ent_sig     = bus.DatoCPU;
                    ocupado_sig = 1'b1;
                end else begin
                    estado_sig  = LEER;
                    hs_sig      = 1'b1;
                    dir_sig     = bus.DireccionCPU;
                    faltan_sig  = bus.Cantidad - 5'd1;
                    ocupado_sig = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Reloj) begin
        if (!Reiniciar) begin
            estado                 <= REPOSO;
            faltan                 <= '0;
            hs_d                   <= 1'b0;
            bus.Ocupado            <= 1'b0;
            bus.DatoLeido          <= '0;
            bus.DatoValido         <= 1'b0;
            bus.Fin                <= 1'b0;
            bus.Error              <= 1'b0;
            bus.HabilitarSalida    <= 1'b0;
            bus.HabilitarEscritura <= 1'b0;
            bus.Direccion          <= '0;
            bus.Entrada            <= '0;
        end else begin
            estado                 <= estado_sig;
            faltan                 <= faltan_sig;
            hs_d                   <= bus.HabilitarSalida;
            bus.Ocupado            <= ocupado_sig;
            bus.DatoLeido          <= dato_sig;
            bus.DatoValido         <= valido_sig;
            bus.Fin                <= fin_sig;
            bus.Error              <= error_sig;
            bus.HabilitarSalida    <= hs_sig;
            bus.HabilitarEscritura <= he_sig;
            bus.Direccion          <= dir_sig;
            bus.Entrada            <= ent_sig;
        end
    end
endmodule

// File: tb/tb_maestro_memoria.sv
// tb_maestro_memoria: directed bench for maestro_memoria with a registered 16x16 memory model.
//   Drives the CPU side of the interface, models the memory, checks against hand-computed values.
module tb_maestro_memoria;
    logic Reloj = 1'b0;
    logic Reiniciar;
    always #5 Reloj = ~Reloj;

    maestro_memoria_if #(.ANCHO_DATOS(16)) bus ();

    maestro_memoria #(.ANCHO_DATOS(16), .PROFUNDIDAD(16), .DIR_PROTEGIDAS(2)) dut (
        .Reloj(Reloj),
        .Reiniciar(Reiniciar),
        .bus(bus)
    );

    logic [15:0] mem [0:15];

    always @(posedge Reloj) begin
        if (bus.HabilitarEscritura) mem[bus.Direccion[3:0]] <= bus.Entrada;
        if (bus.HabilitarSalida) bus.Salida <= mem[bus.Direccion[3:0]];
    end

    int checks = 0;
    int errors = 0;
    int ciclos, nfin, nerr, nhs, nhe, nocup, nambos, t_val, t_fin;
    logic [15:0] leidos [$];
    logic [15:0] dirs [$];
    logic [15:0] dir_esc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic limpiar();
        ciclos = 0; nfin = 0; nerr = 0; nhs = 0; nhe = 0; nocup = 0; t_val = 0; t_fin = 0;
        leidos.delete();
        dirs.delete();
    endtask

    // One clock edge, then log what the DUT presents 1 ns later.
    task automatic ciclo();
        @(posedge Reloj);
        #1;
        ciclos++;
        if (bus.DatoValido) begin
            leidos.push_back(bus.DatoLeido);
            if (t_val == 0) t_val = ciclos;
        end
        if (bus.Fin) begin
            nfin++;
            t_fin = ciclos;
        end
        if (bus.Error) nerr++;
        if (bus.HabilitarSalida) begin
            nhs++;
            dirs.push_back(bus.Direccion);
        end
        if (bus.HabilitarEscritura) begin
            nhe++;
            dir_esc = bus.Direccion;
        end
        if (bus.HabilitarSalida && bus.HabilitarEscritura) nambos++;
        if (bus.Ocupado) nocup++;
    endtask

    task automatic solicitar(input logic escr, input logic [15:0] dir, input logic [15:0] dato, input logic [4:0] cant);
        bus.Solicitud = 1'b1;
        bus.Escribir = escr;
        bus.DireccionCPU = dir;
        bus.DatoCPU = dato;
        bus.Cantidad = cant;
        ciclo();
        bus.Solicitud = 1'b0;
    endtask

    function automatic logic [15:0] esperado(input int i);
        return i == 0 ? 16'h4000 : i == 1 ? 16'h0017 : i == 7 ? 16'h00A5 : 16'h1000 + 16'(i);
    endfunction

    typedef struct {logic escr; logic [15:0] dir; logic [4:0] cant;} rechazo_t;
    rechazo_t rechazos [4];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'h4000;
        mem[1] = 16'h0017;
        bus.Salida = '0;
        nambos = 0;
        rechazos[0] = '{1'b1, 16'h0001, 5'd0};
        rechazos[1] = '{1'b0, 16'h000E, 5'd3};
        rechazos[2] = '{1'b0, 16'h0003, 5'd0};
        rechazos[3] = '{1'b1, 16'h0010, 5'd0};

        Reiniciar = 1'b0;
        bus.Solicitud = 1'b0;
        bus.Escribir = 1'b0;
        bus.DireccionCPU = '0;
        bus.DatoCPU = '0;
        bus.Cantidad = '0;
        limpiar();
        ciclo();
        ciclo();
        check("reset_ctl", {bus.Ocupado, bus.DatoValido, bus.Fin, bus.Error, bus.HabilitarSalida, bus.HabilitarEscritura}, 0);
        check("reset_dir", {bus.Direccion, bus.Entrada}, 0);
        check("reset_dato", bus.DatoLeido, 0);
        Reiniciar = 1'b1;

        // Boot read of the two protected words
        limpiar();
        solicitar(1'b0, 16'h0000, 16'h0000, 5'd2);
        repeat (4) ciclo();
        check("boot_n", leidos.size(), 2);
        check("boot_w0", leidos.size() > 0 ? leidos[0] : 16'hxxxx, 16'h4000);
        check("boot_w1", leidos.size() > 1 ? leidos[1] : 16'hxxxx, 16'h0017);
        check("boot_tval", t_val, 3);
        check("boot_tfin", t_fin, 4);
        check("boot_nfin", nfin, 1);
        check("boot_ocup", nocup, 3);

        // Write 0x00A5 to 0x0007
        limpiar();
        solicitar(1'b1, 16'h0007, 16'h00A5, 5'd0);
        repeat (3) ciclo();
        check("wr_nhe", nhe, 1);
        check("wr_dir", dir_esc, 16'h0007);
        check("wr_tfin", t_fin, 2);
        check("wr_ocup", nocup, 1);
        check("wr_entrada0", bus.Entrada, 16'h0000);

        // Read it back
        limpiar();
        solicitar(1'b0, 16'h0007, 16'h0000, 5'd1);
        repeat (3) ciclo();
        check("rd7_n", leidos.size(), 1);
        check("rd7_w", leidos.size() > 0 ? leidos[0] : 16'hxxxx, 16'h00A5);
        check("rd7_tfin", t_fin, 3);

        // Full 16-word burst
        limpiar();
        solicitar(1'b0, 16'h0000, 16'h0000, 5'd16);
        repeat (20) ciclo();
        check("full_n", leidos.size(), 16);
        check("full_nhs", nhs, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_w%0d", i), leidos.size() > i ? leidos[i] : 16'hxxxx, esperado(i));
            check($sformatf("full_d%0d", i), dirs.size() > i ? dirs[i] : 16'hxxxx, 16'(i));
        end
        check("full_tval", t_val, 3);
        check("full_tfin", t_fin, 18);
        check("full_nfin", nfin, 1);
        check("full_ocup", nocup, 17);

        // Rejected requests: one Error pulse, no strobes, never busy
        foreach (rechazos[k]) begin
            limpiar();
            solicitar(rechazos[k].escr, rechazos[k].dir, 16'h5555, rechazos[k].cant);
            repeat (2) ciclo();
            check($sformatf("rech%0d", k), {8'(nerr), 8'(nhs + nhe), 8'(nocup), 8'(nfin)}, {8'd1, 8'd0, 8'd0, 8'd0});
        end
        check("rech_mem1", mem[1], 16'h0017);

        // Busy: request held through a 4-word read, re-accepted on the Fin edge
        limpiar();
        bus.Solicitud = 1'b1;
        bus.Escribir = 1'b0;
        bus.DireccionCPU = 16'h0004;
        bus.Cantidad = 5'd4;
        repeat (6) ciclo();
        check("busy_fin_edge", {bus.Fin, bus.DatoValido, bus.HabilitarSalida, bus.Ocupado}, 4'b1111);
        check("busy_dir", bus.Direccion, 16'h0004);
        check("busy_nhs1", nhs, 5);
        bus.Solicitud = 1'b0;
        repeat (8) ciclo();
        check("busy_nfin", nfin, 2);
        check("busy_tfin", t_fin, 11);
        check("busy_n", leidos.size(), 8);
        check("busy_w3", leidos.size() > 3 ? leidos[3] : 16'hxxxx, 16'h00A5);
        check("busy_w7", leidos.size() > 7 ? leidos[7] : 16'hxxxx, 16'h00A5);

        // Reset after two strobes of a 4-word read
        limpiar();
        solicitar(1'b0, 16'h0000, 16'h0000, 5'd4);
        ciclo();
        check("rst_pre_nhs", nhs, 2);
        Reiniciar = 1'b0;
        ciclo();
        check("rst_ctl", {bus.HabilitarSalida, bus.HabilitarEscritura, bus.Ocupado, bus.DatoValido, bus.Fin}, 0);
        Reiniciar = 1'b1;
        limpiar();
        repeat (6) ciclo();
        check("rst_after", {8'(leidos.size()), 8'(nhs), 8'(nfin), 8'(nocup)}, 0);

        check("ambos_strobes", nambos, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
